// File: rtl/axis_qam16_demod_if.sv
// Stream bundle for the QAM16 demodulator: sample input side and packed nibble output side.
// The slave view is the demodulator, the master view is whatever feeds and drains it.
interface axis_qam16_demod_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/axis_qam16_demod.sv
// QAM16 hard-decision demodulator: reads 64 subcarriers, keeps the 31 positive
// ones as nibbles and emits them as 4 packed 32-bit words per frame.
module axis_qam16_demod #(
    parameter logic signed [15:0] THRESH = 16'sd8192
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     en,
    output logic                     frame_err,
    axis_qam16_demod_if.slave        axis
);

    typedef enum logic {S_READ, S_WRITE} state_t;

    state_t     state, state_nx;
    logic [5:0] k;
    logic [1:0] j;
    logic [3:0] nib_mem [0:30];
    logic       s_hs;
    logic       m_hs;
    logic [3:0] nib_in;
    logic [4:0] idx;

    function automatic logic [1:0] slice(input logic [15:0] v);
        logic signed [16:0] x;
        logic signed [16:0] t;
        x = {v[15], v};
        t = {THRESH[15], THRESH};
        if (x < -t)
            return 2'b00;
        else if (x < 0)
            return 2'b01;
        else if (x < t)
            return 2'b11;
        else
            return 2'b10;
    endfunction

    assign axis.s_axis_tready = (state == S_READ) && en;
    assign axis.m_axis_tvalid = (state == S_WRITE);
    assign axis.m_axis_tlast  = (state == S_WRITE) && (j == 2'd3);

    assign s_hs   = axis.s_axis_tvalid && axis.s_axis_tready;
    assign m_hs   = axis.m_axis_tvalid && axis.m_axis_tready && en;
    assign nib_in = {slice(axis.s_axis_tdata[31:16]),
                     slice(axis.s_axis_tdata[15:0])};

    always_comb begin
        state_nx = state;
        unique case (state)
            S_READ:  if (s_hs && k == 6'd63) state_nx = S_WRITE;
            S_WRITE: if (m_hs && j == 2'd3)  state_nx = S_READ;
            default: state_nx = S_READ;
        endcase
    end

    // Nibble 31 has no storage; it reads back as zero.
    always_comb begin
        axis.m_axis_tdata = '0;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            idx = {j, 3'(i)};
            axis.m_axis_tdata[31-4*i -: 4] =
                (idx == 5'd31) ? 4'h0 : nib_mem[idx];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= S_READ;
            k         <= '0;
            j         <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < 31; i++)
                nib_mem[i] <= '0;
        end else if (en) begin
            state <= state_nx;
            if (s_hs) begin
                k <= k + 6'd1;
                if (!k[5] && k[4:0] != 5'd0)
                    nib_mem[k[4:0] - 5'd1] <= nib_in;
                if (axis.s_axis_tlast != (k == 6'd63))
                    frame_err <= 1'b1;
            end
            if (m_hs)
                j <= j + 2'd1;
        end
    end

endmodule

// File: tb/tb_axis_qam16_demod.sv
// Directed-plus-random bench for axis_qam16_demod with an arithmetic slicer model.
module tb_axis_qam16_demod;

    localparam int T = 8192;

    logic aclk = 1'b0;
    logic areset;
    logic en;
    logic frame_err;
    int   errors = 0;
    int   checks = 0;

    axis_qam16_demod_if bus ();

    axis_qam16_demod #(.THRESH(16'sd8192)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .en        (en),
        .frame_err (frame_err),
        .axis      (bus)
    );

    always #5 aclk = ~aclk;

    logic [31:0] fr [64];
    logic [31:0] exp_w [4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int sl(input int v);
        if (v < -T) return 0;
        if (v < 0) return 1;
        if (v < T) return 3;
        return 2;
    endfunction

    task automatic model(input logic [31:0] s [64], output logic [31:0] w [4]);
        int nib [32];
        for (int i = 0; i < 32; i++) nib[i] = 0;
        for (int sc = 1; sc < 32; sc++) begin
            int iv, qv;
            iv = int'($signed(s[sc][31:16]));
            qv = int'($signed(s[sc][15:0]));
            nib[sc-1] = sl(iv) * 4 + sl(qv);
        end
        for (int jj = 0; jj < 4; jj++) begin
            w[jj] = 0;
            for (int m = 0; m < 8; m++)
                w[jj] = w[jj] + (32'(nib[8*jj+m]) << (4 * (7 - m)));
        end
    endtask

    task automatic push(input logic [31:0] d, input bit last, input bit rnd);
        int  n = 0;
        bit  done = 0;
        while (!done) begin
            bus.s_axis_tdata  = d;
            bus.s_axis_tlast  = last;
            bus.s_axis_tvalid = 1'b1;
            en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (!en) chk("tready_en0", 32'(bus.s_axis_tready), 0);
            chk("tvalid_in_read", 32'(bus.m_axis_tvalid), 0);
            done = bus.s_axis_tready;
            @(posedge aclk);
            @(negedge aclk);
            n++;
            if (!done && n > 50) begin
                checks++;
                errors++;
                $error("FAIL push_timeout: got no tready expected tready within 50 cycles");
                done = 1;
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        en = 1'b1;
    endtask

    task automatic push_frame(input int last_pos, input bit rnd);
        for (int i = 0; i < 64; i++)
            push(fr[i], i == last_pos, rnd);
    endtask

    task automatic collect(input logic [31:0] w [4], input bit stall);
        for (int jj = 0; jj < 4; jj++) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.m_axis_tready = 1'b0;
                    #1;
                    chk("stall_data", bus.m_axis_tdata, w[jj]);
                    chk("stall_valid", 32'(bus.m_axis_tvalid), 1);
                    chk("stall_last", 32'(bus.m_axis_tlast), 32'(jj == 3));
                    @(posedge aclk);
                    @(negedge aclk);
                end
                if ($urandom_range(0, 1) == 1) begin
                    en = 1'b0;
                    bus.m_axis_tready = 1'b1;
                    #1;
                    chk("en0_hold", bus.m_axis_tdata, w[jj]);
                    @(posedge aclk);
                    @(negedge aclk);
                    en = 1'b1;
                end
            end
            bus.m_axis_tready = 1'b1;
            #1;
            chk("word", bus.m_axis_tdata, w[jj]);
            chk("word_valid", 32'(bus.m_axis_tvalid), 1);
            chk("word_last", 32'(bus.m_axis_tlast), 32'(jj == 3));
            @(posedge aclk);
            @(negedge aclk);
            bus.m_axis_tready = 1'b0;
        end
        #1;
        chk("post_valid", 32'(bus.m_axis_tvalid), 0);
        chk("post_tready", 32'(bus.s_axis_tready), 1);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        areset = 1'b0;
        en = 1'b1;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b0;
        @(negedge aclk);
        do_reset();
        #1;
        chk("rst_tready", 32'(bus.s_axis_tready), 1);
        chk("rst_valid", 32'(bus.m_axis_tvalid), 0);
        chk("rst_last", 32'(bus.m_axis_tlast), 0);
        chk("rst_err", 32'(frame_err), 0);
        en = 1'b0;
        #1;
        chk("rst_tready_en0", 32'(bus.s_axis_tready), 0);
        en = 1'b1;
        @(negedge aclk);

        // All samples in the outer positive cell.
        for (int i = 0; i < 64; i++) fr[i] = 32'h30003000;
        push_frame(63, 0);
        exp_w[0] = 32'hAAAAAAAA; exp_w[1] = 32'hAAAAAAAA;
        exp_w[2] = 32'hAAAAAAAA; exp_w[3] = 32'hAAAAAAA0;
        collect(exp_w, 0);
        chk("err_clean1", 32'(frame_err), 0);

        // Outer-negative I, inner-negative Q.
        for (int i = 0; i < 64; i++) fr[i] = 32'hD000F000;
        push_frame(63, 0);
        exp_w[0] = 32'h11111111; exp_w[1] = 32'h11111111;
        exp_w[2] = 32'h11111111; exp_w[3] = 32'h11111110;
        collect(exp_w, 0);

        // Threshold boundaries on subcarriers 1..4, random elsewhere.
        for (int i = 0; i < 64; i++) fr[i] = $urandom;
        fr[1] = {16'sd0, 16'sd0};
        fr[2] = {16'sd8192, 16'sd8192};
        fr[3] = {-16'sd8192, -16'sd8192};
        fr[4] = {-16'sd8193, 16'sd8191};
        push_frame(63, 0);
        model(fr, exp_w);
        bus.m_axis_tready = 1'b1;
        #1;
        chk("boundary_prefix", 32'(bus.m_axis_tdata[31:16]), 32'h0000FA53);
        bus.m_axis_tready = 1'b0;
        collect(exp_w, 0);

        // Random data with en gaps on input and stalls on output.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) fr[i] = $urandom;
            push_frame(63, 1);
            model(fr, exp_w);
            collect(exp_w, 1);
        end
        chk("err_clean2", 32'(frame_err), 0);

        // Early tlast: sticky error, frame still completes.
        for (int i = 0; i < 64; i++) fr[i] = $urandom;
        push_frame(40, 0);
        chk("err_early_last", 32'(frame_err), 1);
        model(fr, exp_w);
        collect(exp_w, 0);
        for (int i = 0; i < 64; i++) fr[i] = $urandom;
        push_frame(63, 0);
        model(fr, exp_w);
        collect(exp_w, 0);
        chk("err_sticky", 32'(frame_err), 1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 20; i++) push(32'h30003000, 0, 0);
        do_reset();
        #1;
        chk("mid_rst_err", 32'(frame_err), 0);
        chk("mid_rst_valid", 32'(bus.m_axis_tvalid), 0);
        @(negedge aclk);
        for (int i = 0; i < 64; i++) fr[i] = $urandom;
        push_frame(63, 0);
        model(fr, exp_w);
        collect(exp_w, 1);
        chk("err_after_rst", 32'(frame_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_qam16_demod.md
AXIS_QAM16_DEMOD -- requirements
Module: axis_qam16_demod

Interface
REQ-001 SHALL have parameter THRESH, default 8192 (16-bit signed), the outer decision threshold per axis, equal to 2x the unit constellation amplitude.
REQ-002 SHALL have port aclk  input  1  the single clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port areset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port s_axis_tdata  input  32  one subcarrier sample: I = [31:16], Q = [15:0], both two's-complement.
REQ-005 SHALL have port s_axis_tvalid  input  1  upstream sample valid.
REQ-006 SHALL have port s_axis_tlast  input  1  upstream end-of-frame marker, expected on subcarrier 63.
REQ-007 SHALL have port s_axis_tready  output  1  demodulator accepts a sample.
REQ-008 SHALL have port m_axis_tdata  output  32  packed output word, 8 nibbles per word.
REQ-009 SHALL have port m_axis_tvalid  output  1  output word valid.
REQ-010 SHALL have port m_axis_tlast  output  1  last of the 4 words in a frame.
REQ-011 SHALL have port m_axis_tready  input  1  downstream accepts a word.
REQ-012 SHALL have port en  input  1  global enable; when 0, all state, counters and memories hold.
REQ-013 SHALL have port frame_err  output  1  sticky flag: s_axis_tlast misaligned with the subcarrier count.

Function
REQ-014 SHALL implement two states: S_READ (accept 64 subcarriers) and S_WRITE (emit 4 words).
REQ-015 SHALL drive s_axis_tready = 1 only when the state is S_READ and en = 1; an input handshake is s_axis_tvalid & s_axis_tready.
REQ-016 SHALL keep a 6-bit subcarrier counter k, starting at 0 and incremented on each input handshake.
REQ-017 SHALL slice each axis value v combinationally: v < -THRESH -> 00; -THRESH <= v < 0 -> 01; 0 <= v < THRESH -> 11; v >= THRESH -> 10. All comparisons are signed.
REQ-018 SHALL form each symbol nibble as {I bits, Q bits}, with the I bits in [3:2].
REQ-019 SHALL write the nibble into a 32-entry nibble memory at index k-1 on a handshake for k = 1..31 only.
REQ-020 SHALL discard the data of subcarriers 0 (DC), 32 (Nyquist) and 33..63 (conjugate half), while still counting them.
REQ-021 SHALL hold nibble index 31 at 0 at all times.
REQ-022 SHALL, on the handshake with k = 63, reset k to 0 and move to S_WRITE in the next cycle; the output latency is therefore 1 cycle after the last input.
REQ-023 SHALL set frame_err when a handshake has s_axis_tlast = 1 with k != 63, or s_axis_tlast = 0 with k = 63; counting is not altered by this check.
REQ-024 SHALL clear frame_err only by reset.
REQ-025 SHALL drive m_axis_tvalid = 1 throughout S_WRITE.
REQ-026 SHALL build output word j (0..3) as nibble[8j] in [31:28] down to nibble[8j+7] in [3:0].
REQ-027 SHALL drive m_axis_tlast = 1 only when j = 3 and the state is S_WRITE.
REQ-028 SHALL advance j on each output handshake; the handshake on j = 3 returns to S_READ with j = 0 in the next cycle.
REQ-029 SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable while m_axis_tready = 0.
REQ-030 SHALL, when en = 0, block handshakes in both directions: s_axis_tready = 0, and j does not advance even if m_axis_tready = 1.

Reset
REQ-031 SHALL, on areset = 1 at a clock edge, set: state S_READ, k = 0, j = 0, all nibble memory to 0, frame_err = 0.
REQ-032 SHALL produce these output values after reset: s_axis_tready = en, m_axis_tvalid = 0, m_axis_tlast = 0.
REQ-033 SHALL give areset priority over en, and a reset mid-frame SHALL abandon the partial frame.

Verification
REQ-034 SHALL cover: 64 samples of 0x30003000 (tlast on #63), m_axis_tready = 1 -> words 0xAAAAAAAA, 0xAAAAAAAA, 0xAAAAAAAA, 0xAAAAAAA0, tlast on word 3, frame_err = 0.
REQ-035 SHALL cover: all samples 0xD000F000 -> nibble 0x1 -> words 0x11111111 x3, then 0x11111110.
REQ-036 SHALL cover: subcarriers 1..4 with I/Q = 0/0, 8192/8192, -8192/-8192, -8193/8191 -> nibbles 0xF, 0xA, 0x5, 0x3; first word begins 0xFA53.
REQ-037 SHALL cover: m_axis_tready toggled 0/1 during S_WRITE and en = 0 pulses during S_READ -> no lost or duplicated sample or word; outputs stable while stalled.
REQ-038 SHALL cover: tlast asserted on sample #40 -> frame_err = 1 and stays 1; the frame still outputs 4 words after 64 samples.
REQ-039 SHALL cover: areset asserted after 20 samples -> next 64 samples form a clean frame; stale nibbles do not appear in the output.
